// File: rtl/alu4_arb.sv
// -----------------------------------------------------------------------------
// alu4_arb -- round-robin scheduler sharing one combinational ALU4 between two
// requesters (A and B). One request is granted at a time. Its opcode and
// operands are captured at the handshake and then drive the ALU for one cycle.
// The result is registered into a single-entry output stage that is tagged
// with the source. Back-to-back operations take three cycles:
// grant, execute, and result handshake.
//
// Optional feature macro: ALU4_ARB_STATS_EN
//   When defined, saturating per-requester grant counters a_cnt/b_cnt are
//   added (width CNT_W). When undefined, the counters and ports are absent.
//
// Ports
//   clk                       clock, rising edge
//   rst                       asynchronous reset, active high
//   a_valid/a_op/a_lt/a_rt    requester A request (opcode, left, right)
//   a_ready                   A accepted this cycle (combinational grant)
//   b_valid/b_op/b_lt/b_rt    requester B request
//   b_ready                   B accepted this cycle
//   r_valid/r_ready           result stage handshake
//   r_data                    registered ALU result
//   r_src                     0 = result for A, 1 = result for B
//   a_cnt/b_cnt               grant counters (ALU4_ARB_STATS_EN only)
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// alu4 -- shared 4-bit combinational ALU. Arithmetic wraps at 4 bits and the
// carry is discarded. Undefined opcodes produce zero.
//   op_i  opcode
//   lt_i  left operand
//   rt_i  right operand
//   y_o   result
// -----------------------------------------------------------------------------
module alu4 (
  input  logic [3:0] op_i,
  input  logic [3:0] lt_i,
  input  logic [3:0] rt_i,
  output logic [3:0] y_o
);

  // Opcode decode for the shared datapath
  always_comb begin
    y_o = 4'h0;
    case (op_i)
      4'b0000: y_o = lt_i & rt_i;                          // AND
      4'b0001: y_o = lt_i | rt_i;                          // OR
      4'b0010: y_o = lt_i + rt_i;                          // ADD, carry dropped
      4'b0011: y_o = lt_i ^ rt_i;                          // XOR
      4'b0110: y_o = lt_i - rt_i;                          // SUB, borrow dropped
      4'b0111: y_o = {3'b000, (lt_i < rt_i)};              // set-less-than
      4'b1100: y_o = ~(lt_i | rt_i);                       // NOR
      default: y_o = 4'h0;
    endcase
  end

endmodule

module alu4_arb #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [3:0]       a_op,
  input  logic [3:0]       a_lt,
  input  logic [3:0]       a_rt,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [3:0]       b_op,
  input  logic [3:0]       b_lt,
  input  logic [3:0]       b_rt,
  output logic             b_ready,
  output logic             r_valid,
  input  logic             r_ready,
  output logic [3:0]       r_data,
  output logic             r_src
`ifdef ALU4_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] a_cnt,
  output logic [CNT_W-1:0] b_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  state_t     state_q;
  logic       ptr_q;      // 1 = B wins a tie, 0 = A wins a tie
  logic [3:0] op_q;
  logic [3:0] lt_q;
  logic [3:0] rt_q;
  logic       src_q;
  logic       r_valid_q;
  logic [3:0] r_data_q;
  logic       r_src_q;

  logic       grant_a_s;
  logic       grant_b_s;
  logic [3:0] alu_y_s;

  // Grant selection. Only IDLE can grant. On a tie, ptr picks the winner.
  // Grants are masked while rst is high so that readies stay low during reset.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if ((state_q == ST_IDLE) && !rst) begin
      if (a_valid && b_valid) begin
        grant_a_s = ~ptr_q;
        grant_b_s = ptr_q;
      end else begin
        grant_a_s = a_valid;
        grant_b_s = b_valid;
      end
    end else begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end
  end

  assign a_ready = grant_a_s;
  assign b_ready = grant_b_s;

  // The ALU only ever sees the captured operands, so requesters may change
  // their inputs freely once the handshake has happened.
  alu4 u_alu4 (
    .op_i (op_q),
    .lt_i (lt_q),
    .rt_i (rt_q),
    .y_o  (alu_y_s)
  );

  // Scheduler FSM: capture on grant, execute, then hold the result until it is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 1'b0;
      op_q      <= 4'h0;
      lt_q      <= 4'h0;
      rt_q      <= 4'h0;
      src_q     <= 1'b0;
      r_valid_q <= 1'b0;
      r_data_q  <= 4'h0;
      r_src_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_a_s) begin
            op_q    <= a_op;
            lt_q    <= a_lt;
            rt_q    <= a_rt;
            src_q   <= 1'b0;
            state_q <= ST_EXEC;
          end else if (grant_b_s) begin
            op_q    <= b_op;
            lt_q    <= b_lt;
            rt_q    <= b_rt;
            src_q   <= 1'b1;
            state_q <= ST_EXEC;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          r_data_q  <= alu_y_s;
          r_src_q   <= src_q;
          r_valid_q <= 1'b1;
          state_q   <= ST_HOLD;
        end
        ST_HOLD: begin
          if (r_ready) begin
            r_valid_q <= 1'b0;
            // The side just served loses priority on the next tie.
            ptr_q     <= ~r_src_q;
            state_q   <= ST_IDLE;
          end else begin
            state_q   <= ST_HOLD;
          end
        end
        default: begin
          r_valid_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign r_valid = r_valid_q;
  assign r_data  = r_data_q;
  assign r_src   = r_src_q;

`ifdef ALU4_ARB_STATS_EN
  logic [CNT_W-1:0] a_cnt_q;
  logic [CNT_W-1:0] a_cnt_d;
  logic [CNT_W-1:0] b_cnt_q;
  logic [CNT_W-1:0] b_cnt_d;

  // Saturating increment: an all-ones count stays at all ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + CNT_W'(1);
    end
    return r;
  endfunction

  // Next-state for the grant counters. Each grant is a handshake because the
  // ready signal is only raised when the matching valid is high.
  always_comb begin
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    if (grant_a_s) begin
      a_cnt_d = sat_inc(a_cnt_q);
    end else begin
      a_cnt_d = a_cnt_q;
    end
    if (grant_b_s) begin
      b_cnt_d = sat_inc(b_cnt_q);
    end else begin
      b_cnt_d = b_cnt_q;
    end
  end

  // Grant counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
    end
  end

  assign a_cnt = a_cnt_q;
  assign b_cnt = b_cnt_q;
`endif

endmodule

// File: tb/tb_alu4_arb.sv
module tb_alu4_arb;

`ifdef ALU4_ARB_STATS_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 8;
`endif

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_valid, b_valid, a_ready, b_ready;
  logic [3:0] a_op, a_lt, a_rt, b_op, b_lt, b_rt;
  logic       r_valid, r_ready, r_src;
  logic [3:0] r_data;
`ifdef ALU4_ARB_STATS_EN
  logic [CNT_W-1:0] a_cnt, b_cnt;
`endif

  alu4_arb #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_op    (a_op),
    .a_lt    (a_lt),
    .a_rt    (a_rt),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_op    (b_op),
    .b_lt    (b_lt),
    .b_rt    (b_rt),
    .b_ready (b_ready),
    .r_valid (r_valid),
    .r_ready (r_ready),
    .r_data  (r_data),
    .r_src   (r_src)
`ifdef ALU4_ARB_STATS_EN
    ,
    .a_cnt   (a_cnt),
    .b_cnt   (b_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference ALU written from the opcode meanings
  function automatic logic [3:0] ref_alu(input logic [3:0] op, input logic [3:0] lt, input logic [3:0] rt);
    int s;
    case (op)
      OP_AND:  s = int'(lt & rt);
      OP_ADD:  s = (int'(lt) + int'(rt)) % 16;
      OP_SUB:  s = (int'(lt) - int'(rt) + 16) % 16;
      default: s = 0;
    endcase
    return 4'(s);
  endfunction

  // Transaction-level model: outstanding results queue plus priority and timing rules
  typedef struct {
    logic [3:0] data;
    logic       src;
    int         rdy;
  } res_t;

  res_t mq[$];
  int   last_rhs = -1;
  logic prio_b = 1'b0;
  int   na = 0;
  int   nb = 0;

  function automatic int sat(input int n);
    int mx;
    mx = (1 << CNT_W) - 1;
    return (n > mx) ? mx : n;
  endfunction

  // Compare one cycle at the falling edge, update the model, then advance to posedge+1
  task automatic step();
    logic can, ea, eb, ev;
    @(negedge clk);
    if (rst) begin
      chk("rst_a_ready", 16'(a_ready), 16'd0);
      chk("rst_b_ready", 16'(b_ready), 16'd0);
      chk("rst_r_valid", 16'(r_valid), 16'd0);
      chk("rst_r_data", 16'(r_data), 16'd0);
      chk("rst_r_src", 16'(r_src), 16'd0);
      mq.delete();
      last_rhs = -1;
      prio_b = 1'b0;
      na = 0;
      nb = 0;
`ifdef ALU4_ARB_STATS_EN
      chk("rst_a_cnt", 16'(a_cnt), 16'd0);
      chk("rst_b_cnt", 16'(b_cnt), 16'd0);
`endif
    end else begin
      can = (mq.size() == 0) && (cyc > last_rhs);
      ea = can && a_valid && (!b_valid || !prio_b);
      eb = can && b_valid && (!a_valid || prio_b);
      ev = (mq.size() != 0) && (cyc >= mq[0].rdy);
      chk("model_a_ready", 16'(a_ready), 16'(ea));
      chk("model_b_ready", 16'(b_ready), 16'(eb));
      chk("model_r_valid", 16'(r_valid), 16'(ev));
      if (ev) begin
        chk("model_r_data", 16'(r_data), 16'(mq[0].data));
        chk("model_r_src", 16'(r_src), 16'(mq[0].src));
      end
`ifdef ALU4_ARB_STATS_EN
      chk("model_a_cnt", 16'(a_cnt), 16'(sat(na)));
      chk("model_b_cnt", 16'(b_cnt), 16'(sat(nb)));
`endif
      if (ev && r_ready) begin
        prio_b = !mq[0].src;
        last_rhs = cyc;
        void'(mq.pop_front());
      end
      if (ea) begin
        mq.push_back('{ref_alu(a_op, a_lt, a_rt), 1'b0, cyc + 2});
        na++;
      end
      if (eb) begin
        mq.push_back('{ref_alu(b_op, b_lt, b_rt), 1'b1, cyc + 2});
        nb++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_side(input logic side, input logic v, input logic [3:0] op,
                            input logic [3:0] lt, input logic [3:0] rt);
    if (side) begin
      b_valid = v; b_op = op; b_lt = lt; b_rt = rt;
    end else begin
      a_valid = v; a_op = op; a_lt = lt; a_rt = rt;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Wait (bounded) until either ready is high; the caller checks the outcome
  task automatic wait_grant(input string name);
    int k;
    k = 0;
    #2;
    while (!(a_ready || b_ready) && k < 6) begin
      step();
      #2;
      k++;
    end
    chk(name, 16'(a_ready || b_ready), 16'd1);
  endtask

  typedef struct {
    logic       side;
    logic [3:0] op;
    logic [3:0] lt;
    logic [3:0] rt;
    logic [3:0] exp;
  } vec_t;

  vec_t       vt[6];
  logic [3:0] ops[3];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_op = 4'h0; a_lt = 4'h0; a_rt = 4'h0;
    b_valid = 1'b0; b_op = 4'h0; b_lt = 4'h0; b_rt = 4'h0;
    r_ready = 1'b1;
    ops[0] = OP_AND; ops[1] = OP_ADD; ops[2] = OP_SUB;

    vt[0] = '{1'b0, OP_ADD, 4'd3, 4'd5, 4'h8};
    vt[1] = '{1'b0, OP_ADD, 4'hF, 4'h1, 4'h0};
    vt[2] = '{1'b1, OP_SUB, 4'd7, 4'd2, 4'h5};
    vt[3] = '{1'b1, OP_AND, 4'hC, 4'hA, 4'h8};
    vt[4] = '{1'b0, OP_SUB, 4'h0, 4'h1, 4'hF};
    vt[5] = '{1'b1, OP_ADD, 4'h9, 4'h9, 4'h2};

    do_reset();

    // Single-requester vectors: ready pulse, latency of two, return to IDLE
    for (int i = 0; i < 6; i++) begin
      r_ready = 1'b1;
      drive_side(vt[i].side, 1'b1, vt[i].op, vt[i].lt, vt[i].rt);
      #2;
      chk("vec_ready", 16'(vt[i].side ? b_ready : a_ready), 16'd1);
      chk("vec_other_ready", 16'(vt[i].side ? a_ready : b_ready), 16'd0);
      step();
      drive_side(vt[i].side, 1'b0, 4'($urandom), 4'($urandom), 4'($urandom));
      #2;
      chk("vec_ready_drop", 16'(vt[i].side ? b_ready : a_ready), 16'd0);
      chk("vec_exec_r_valid", 16'(r_valid), 16'd0);
      step();
      #2;
      chk("vec_r_valid", 16'(r_valid), 16'd1);
      chk("vec_r_data", 16'(r_data), 16'(vt[i].exp));
      chk("vec_r_src", 16'(r_src), 16'(vt[i].side));
      step();
      #2;
      chk("vec_idle_r_valid", 16'(r_valid), 16'd0);
      step();
    end

    // Both valid from reset: grants alternate A, B, A, B
    do_reset();
    drive_side(1'b0, 1'b1, OP_SUB, 4'd7, 4'd2);
    drive_side(1'b1, 1'b1, OP_AND, 4'hC, 4'hA);
    r_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      wait_grant("alt_grant_seen");
      chk("alt_a_ready", 16'(a_ready), 16'((g % 2) == 0));
      chk("alt_b_ready", 16'(b_ready), 16'((g % 2) == 1));
      step();
      step();
      #2;
      chk("alt_r_valid", 16'(r_valid), 16'd1);
      chk("alt_r_data", 16'(r_data), ((g % 2) == 0) ? 16'h5 : 16'h8);
      chk("alt_r_src", 16'(r_src), 16'(g % 2));
      step();
    end

    // Result back-pressure: 10 stalled cycles in HOLD with both requesters waiting
    r_ready = 1'b0;
    wait_grant("bp_grant_seen");
    chk("bp_a_ready", 16'(a_ready), 16'd1);
    step();
    step();
    for (int k = 0; k < 10; k++) begin
      #2;
      chk("bp_r_valid", 16'(r_valid), 16'd1);
      chk("bp_r_data", 16'(r_data), 16'h5);
      chk("bp_r_src", 16'(r_src), 16'd0);
      chk("bp_a_ready", 16'(a_ready), 16'd0);
      chk("bp_b_ready", 16'(b_ready), 16'd0);
      step();
    end
    r_ready = 1'b1;
    step();
    #2;
    chk("bp_next_b_ready", 16'(b_ready), 16'd1);
    chk("bp_next_a_ready", 16'(a_ready), 16'd0);
    step();

    // Reset while B's operation is in EXEC: outputs clear at once, result is lost
    rst = 1'b1;
    #1;
    chk("mid_rst_r_valid", 16'(r_valid), 16'd0);
    chk("mid_rst_r_data", 16'(r_data), 16'd0);
    chk("mid_rst_a_ready", 16'(a_ready), 16'd0);
    chk("mid_rst_b_ready", 16'(b_ready), 16'd0);
    step();
    rst = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("post_rst_no_result", 16'(r_valid), 16'd0);
      step();
    end
    a_valid = 1'b1;
    b_valid = 1'b1;
    #2;
    chk("post_rst_ptr_a", 16'(a_ready), 16'd1);
    chk("post_rst_ptr_b", 16'(b_ready), 16'd0);
    step();
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (4) step();

    // Randomized traffic against the model, with occasional resets
    for (int c = 0; c < 500; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      a_valid = ($urandom_range(0, 2) != 0);
      a_op = ops[$urandom_range(0, 2)];
      a_lt = 4'($urandom);
      a_rt = 4'($urandom);
      b_valid = ($urandom_range(0, 2) != 0);
      b_op = ops[$urandom_range(0, 2)];
      b_lt = 4'($urandom);
      b_rt = 4'($urandom);
      r_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 1'b0;

`ifdef ALU4_ARB_STATS_EN
    // Five A grants saturate a 2-bit counter at 3
    do_reset();
    drive_side(1'b0, 1'b1, OP_ADD, 4'd1, 4'd2);
    r_ready = 1'b1;
    repeat (15) step();
    #2;
    chk("stats_a_cnt_sat", 16'(a_cnt), 16'd3);
    chk("stats_b_cnt", 16'(b_cnt), 16'd0);
    a_valid = 1'b0;
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
